// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: memop codes, FSM states, alignment rule.
// Used by dmem_access_ctrl and dmem_align_chk (alignment check built with DMEM_ALIGN_CHECK_EN).
package dmem_ctrl_pkg;

    localparam logic [2:0] MOP_B  = 3'b000;
    localparam logic [2:0] MOP_H  = 3'b001;
    localparam logic [2:0] MOP_W  = 3'b010;
    localparam logic [2:0] MOP_BU = 3'b100;
    localparam logic [2:0] MOP_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } ctrl_state_t;

    // Halfwords need an even address, words a 4-byte aligned one; bytes are always aligned.
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        if ((op == MOP_H || op == MOP_HU) && addr_lo[0])
            bad = 1'b1;
        if (op == MOP_W && addr_lo != 2'b00)
            bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/dmem_align_chk.sv
// Combinational misalignment detector for a memop and the low two address bits.
// Instantiated by dmem_access_ctrl only when DMEM_ALIGN_CHECK_EN is defined.
module dmem_align_chk
    import dmem_ctrl_pkg::*;
(
    input  logic [2:0] i_op,
    input  logic [1:0] i_addr_lo,
    output logic       o_misaligned
);

    assign o_misaligned = is_misaligned(i_op, i_addr_lo);

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequencer between the CPU load/store port and the dual-strobe dmem (read-merge-write stores).
// Optional feature: define DMEM_ALIGN_CHECK_EN to reject misaligned h/hu/w accesses with rsp_err.
module dmem_access_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_op,
    input  logic [AW-1:0]    req_addr,
    input  logic [DW-1:0]    req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DW-1:0]    rsp_rdata,
    output logic             rsp_err,
    output logic [AW-1:0]    m_addr,
    output logic [DW-1:0]    m_datain,
    output logic [2:0]       m_memop,
    output logic             m_we,
    output logic             m_rdclk,
    output logic             m_wrclk,
    input  logic [DW-1:0]    m_dataout,
    output logic [CNT_W-1:0] ld_cnt,
    output logic [CNT_W-1:0] st_cnt
);

    ctrl_state_t      r_state;
    logic             r_req_ready;
    logic             r_rsp_valid;
    logic [DW-1:0]    r_rsp_rdata;
    logic             r_rsp_err;
    logic [AW-1:0]    r_m_addr;
    logic [DW-1:0]    r_m_datain;
    logic [2:0]       r_m_memop;
    logic             r_m_we;
    logic             r_m_rdclk;
    logic             r_m_wrclk;
    logic [CNT_W-1:0] r_ld_cnt;
    logic [CNT_W-1:0] r_st_cnt;
    logic             w_misaligned;

`ifdef DMEM_ALIGN_CHECK_EN
    dmem_align_chk u_align_chk (
        .i_op         (req_op),
        .i_addr_lo    (req_addr[1:0]),
        .o_misaligned (w_misaligned)
    );
`else
    assign w_misaligned = 1'b0;
`endif

    // Strobes are set one state early so each is a clean registered pulse for exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_m_addr    <= '0;
            r_m_datain  <= '0;
            r_m_memop   <= '0;
            r_m_we      <= 1'b0;
            r_m_rdclk   <= 1'b0;
            r_m_wrclk   <= 1'b0;
            r_ld_cnt    <= '0;
            r_st_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_m_addr    <= req_addr;
                        r_m_datain  <= req_wdata;
                        r_m_memop   <= req_op;
                        r_m_we      <= req_we;
                        r_req_ready <= 1'b0;
                        if (w_misaligned) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_state     <= RESP;
                        end else begin
                            r_m_rdclk <= 1'b1;
                            r_state   <= RD;
                        end
                    end
                end
                RD: begin
                    r_m_rdclk <= 1'b0;
                    if (r_m_we) begin
                        r_m_wrclk   <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_state     <= WR;
                    end else begin
                        r_rsp_rdata <= m_dataout;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                WR: begin
                    r_m_wrclk   <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_m_we      <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                        // Rejected accesses never touched memory, so they are not counted.
                        if (!r_rsp_err) begin
                            if (r_m_we)
                                r_st_cnt <= r_st_cnt + CNT_W'(1);
                            else
                                r_ld_cnt <= r_ld_cnt + CNT_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign m_addr    = r_m_addr;
    assign m_datain  = r_m_datain;
    assign m_memop   = r_m_memop;
    assign m_we      = r_m_we;
    assign m_rdclk   = r_m_rdclk;
    assign m_wrclk   = r_m_wrclk;
    assign ld_cnt    = r_ld_cnt;
    assign st_cnt    = r_st_cnt;

endmodule
